// File: rtl/dez_sec.sv
// Tens-of-seconds BCD down-counter stage with borrow chaining, pause and terminal DONE mode.
// Optional macro DEZSEC_SYNC2_EN adds a two-flop synchronizer on borrow_in.
module dez_sec #(
  parameter int unsigned MODULUS = 6
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       borrow_in,
  input  logic       Us,
  input  logic       alin,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       stop_at_zero,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       borrow_out,
  output logic       zero,
  output logic       done
);

  localparam logic [3:0] CMAX = 4'(MODULUS - 1);
  localparam logic [4:0] MOD5 = 5'(MODULUS);

  typedef enum logic [1:0] {RUN, HOLD, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       bo_q, bo_d;
  logic       done_q, done_d;
  logic       b_q;
  logic       bin;
  logic       ev;
  logic       pause;

`ifdef DEZSEC_SYNC2_EN
  logic s1_q, s2_q;

  // Sync flops reset high so a borrow_in held high across reset is not seen as an edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= borrow_in;
      s2_q <= s1_q;
    end
  end

  assign bin = s2_q;
`else
  assign bin = borrow_in;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) b_q <= 1'b1;
    else       b_q <= bin;
  end

  assign ev    = bin & ~b_q;
  assign pause = Us | alin;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bo_d    = 1'b0;
    if (load) begin
      cnt_d   = ({1'b0, load_val} >= MOD5) ? CMAX : load_val;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (ev) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 4'd1;
            end else if (!stop_at_zero) begin
              cnt_d = CMAX;
              bo_d  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        HOLD: begin
          if (!pause) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= RUN;
      cnt_q   <= '0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign {A, B, C, D} = cnt_q;
  assign borrow_out   = bo_q;
  assign done         = done_q;
  assign zero         = (cnt_q == '0);

endmodule

// File: tb/tb_dez_sec.sv
// Scoreboard bench for dez_sec: driver pushes model predictions, monitor pops and compares.
module tb_dez_sec;

  localparam int MOD = 6;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       borrow_in = 1'b0;
  logic       Us = 1'b0;
  logic       alin = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       stop_at_zero = 1'b0;
  logic       A, B, C, D, borrow_out, zero, done;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];

  // Reference model: count value, mode (0 run, 1 paused, 2 finished), last borrow level.
  int m_cnt = 0;
  int m_st  = 0;
  bit m_bq  = 1'b1;
  bit m_bo  = 1'b0;

  dez_sec #(.MODULUS(MOD)) dut (
    .clk(clk), .clear(clear), .borrow_in(borrow_in), .Us(Us), .alin(alin),
    .load(load), .load_val(load_val), .stop_at_zero(stop_at_zero),
    .A(A), .B(B), .C(C), .D(D), .borrow_out(borrow_out), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic c, input logic bi, input logic us, input logic al,
                     input logic ld, input logic [3:0] lv, input logic saz);
    bit ev;
    @(negedge clk);
    clear = c; borrow_in = bi; Us = us; alin = al;
    load = ld; load_val = lv; stop_at_zero = saz;
    if (c) begin
      m_cnt = 0; m_st = 0; m_bq = 1'b1; m_bo = 1'b0;
    end else begin
      ev   = bi && !m_bq;
      m_bq = bi;
      m_bo = 1'b0;
      if (ld) begin
        m_cnt = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
        m_st  = 0;
      end else if (m_st == 1) begin
        if (!(us || al)) m_st = 0;
      end else if (m_st == 0) begin
        if (us || al) m_st = 1;
        else if (ev) begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (!saz) begin m_cnt = MOD - 1; m_bo = 1'b1; end
          else m_st = 2;
        end
      end
    end
    exp_q.push_back({4'(m_cnt), m_bo, (m_st == 2), (m_cnt == 0)});
  endtask

  // Idle cycle helper
  task automatic idle(input int n, input logic saz);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, saz);
  endtask

  task automatic pulse(input logic us, input logic al, input logic saz);
    cyc(1'b0, 1'b1, us, al, 1'b0, 4'd0, saz);
    cyc(1'b0, 1'b0, us, al, 1'b0, 4'd0, saz);
  endtask

  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",      int'({A, B, C, D}), int'(e[6:3]));
        chk("borrow_out", int'(borrow_out),   int'(e[2]));
        chk("done",       int'(done),         int'(e[1]));
        chk("zero",       int'(zero),         int'(e[0]));
      end
    end
  end

  initial begin : driver
    #2;
    chk("reset_count", int'({A, B, C, D}), 0);
    chk("reset_bo",    int'(borrow_out),   0);
    chk("reset_done",  int'(done),         0);
    chk("reset_zero",  int'(zero),         1);

    // Preset 3, long borrow level gives a single decrement
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(2, 1'b0);

    // Wrap from 0 with borrow_out
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Pause via Us then alin, then resume
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);

    // Terminal mode, then preset 9 clamps to 5
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
    idle(2, 1'b0);

    // Load coincident with an edge at count 0
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(1, 1'b0);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, 1'($urandom % 2), 1'($urandom % 8 == 0), 1'($urandom % 10 == 0),
          1'($urandom % 16 == 0), 4'($urandom % 16), 1'($urandom % 4 == 0));
    end

    // Asynchronous clear while borrow_out is high, released with borrow_in high
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_clear_bo", int'(borrow_out), 1);
    #1;
    clear = 1'b1;
    #1;
    chk("async_count", int'({A, B, C, D}), 0);
    chk("async_bo",    int'(borrow_out),   0);
    chk("async_done",  int'(done),         0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    @(posedge clk);
    #3;
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
